// File: rtl/cmp_drain.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_drain
//  Purpose  : Drain stage of the compute cubic. Accumulates a group of
//             SIZE x SIZE partial-sum tiles (K-split of one output tile),
//             then requantizes each element (round half up, arithmetic
//             right shift, saturate) and streams the result one row per
//             beat on a valid/ready interface.
//  Ports    : clock, rst_n          - clock / async active-low reset
//             acc_in/valid/last     - tile input, acc_in[row][col]
//             acc_ready             - tile can be accepted (ACCUM state)
//             cfg_shift             - shift amount, sampled on last-tile accept
//             out_data/row/valid    - requantized row, lane c = column c
//             out_last/out_sat      - last row flag / any lane clipped
//             out_ready             - downstream accepts current row
//             err                   - sticky: tile offered while not ready
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_drain #(
   parameter int SIZE      = 8,
   parameter int DATA_WID  = 16,
   parameter int ACC_WID   = 48,
   parameter int SHIFT_WID = 6
) (
   input  logic                                    clock,
   input  logic                                    rst_n,
   input  logic [SIZE-1:0][SIZE-1:0][ACC_WID-1:0]  acc_in,
   input  logic                                    acc_valid,
   input  logic                                    acc_last,
   output logic                                    acc_ready,
   input  logic [SHIFT_WID-1:0]                    cfg_shift,
   output logic [SIZE-1:0][DATA_WID-1:0]           out_data,
   output logic [$clog2(SIZE)-1:0]                 out_row,
   output logic                                    out_valid,
   output logic                                    out_last,
   output logic                                    out_sat,
   input  logic                                    out_ready,
   output logic                                    err
);

   localparam int ROW_WID = $clog2(SIZE);
   localparam logic [ROW_WID-1:0] LAST_ROW = ROW_WID'(SIZE - 1);

   // Saturation bounds expressed at the widened (ACC_WID+1) working width.
   localparam logic signed [ACC_WID:0] SAT_MAX =
      (ACC_WID+1)'((64'sd1 <<< (DATA_WID - 1)) - 64'sd1);
   localparam logic signed [ACC_WID:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                                 state;
   state_t                                 state_next;
   logic                                   first;
   logic [SIZE-1:0][SIZE-1:0][ACC_WID-1:0] buffer;
   logic [ROW_WID-1:0]                     row;
   logic [SHIFT_WID-1:0]                   shift_q;
   logic                                   accept;
   logic                                   handshake;

   // Returns {saturated, value}. The rounding add is done one bit wider than
   // the accumulator so that x + half cannot overflow.
   function automatic logic [DATA_WID:0] requant(
      input logic [ACC_WID-1:0]   x,
      input logic [SHIFT_WID-1:0] s
   );
      logic signed [ACC_WID:0] ext;
      logic signed [ACC_WID:0] rnd;
      logic signed [ACC_WID:0] y;
      logic                    sat;
      logic [DATA_WID-1:0]     val;
      ext = signed'({x[ACC_WID-1], x});
      rnd = '0;
      if (s == '0) begin
         y = ext;
      end else if (32'(s) >= ACC_WID) begin
         // Shifting everything out leaves only the sign.
         y = {(ACC_WID+1){x[ACC_WID-1]}};
      end else begin
         rnd = (ACC_WID+1)'(1) <<< (s - 1'b1);
         y   = (ext + rnd) >>> s;
      end
      sat = 1'b0;
      val = y[DATA_WID-1:0];
      if (y > SAT_MAX) begin
         sat = 1'b1;
         val = SAT_MAX[DATA_WID-1:0];
      end else if (y < SAT_MIN) begin
         sat = 1'b1;
         val = SAT_MIN[DATA_WID-1:0];
      end
      return {sat, val};
   endfunction

   // ------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      acc_ready  = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_ACCUM: begin
            acc_ready = 1'b1;
            if (acc_valid && acc_last) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (row == LAST_ROW)) state_next = ST_ACCUM;
         end
         default: state_next = ST_ACCUM;
      endcase
   end

   assign accept    = acc_valid & acc_ready;
   assign handshake = out_valid & out_ready;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath: accumulation buffer, row pointer, shift capture, error flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         first   <= 1'b1;
         buffer  <= '0;
         row     <= '0;
         shift_q <= '0;
         err     <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < SIZE; r++) begin
               for (int c = 0; c < SIZE; c++) begin
                  buffer[r][c] <= first ? acc_in[r][c]
                                        : buffer[r][c] + acc_in[r][c];
               end
            end
            // A last tile closes the group, so the next accept starts fresh.
            first <= acc_last;
            if (acc_last) begin
               shift_q <= cfg_shift;
               row     <= '0;
            end
         end
         if (handshake) begin
            row <= row + 1'b1;
            if (row == LAST_ROW) first <= 1'b1;
         end
         if (acc_valid && !acc_ready) err <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Requantized output row, combinational from buffer[row]
   // ------------------------------------------------------------------------
   always_comb begin
      logic [DATA_WID:0] res;
      res      = '0;
      out_data = '0;
      out_sat  = 1'b0;
      for (int c = 0; c < SIZE; c++) begin
         res = requant(buffer[row][c], shift_q);
         if (state == ST_DRAIN) begin
            out_data[c] = res[DATA_WID-1:0];
            out_sat     = out_sat | res[DATA_WID];
         end
      end
   end

   assign out_row  = row;
   assign out_last = (state == ST_DRAIN) && (row == LAST_ROW);

endmodule
`default_nettype wire

// File: tb/tb_cmp_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_drain
//  Purpose  : Directed self-checking bench for cmp_drain. Inputs are driven
//             and outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_drain;

   localparam int SIZE = 8;
   localparam int DW   = 16;
   localparam int AW   = 48;
   localparam int SW   = 6;

   logic                             clock;
   logic                             rst_n;
   logic [SIZE-1:0][SIZE-1:0][AW-1:0] acc_in;
   logic                             acc_valid;
   logic                             acc_last;
   logic                             acc_ready;
   logic [SW-1:0]                    cfg_shift;
   logic [SIZE-1:0][DW-1:0]          out_data;
   logic [2:0]                       out_row;
   logic                             out_valid;
   logic                             out_last;
   logic                             out_sat;
   logic                             out_ready;
   logic                             err;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_lane [SIZE];
   logic          exp_sat  [SIZE];

   cmp_drain #(.SIZE(SIZE), .DATA_WID(DW), .ACC_WID(AW), .SHIFT_WID(SW)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .acc_in    (acc_in),
      .acc_valid (acc_valid),
      .acc_last  (acc_last),
      .acc_ready (acc_ready),
      .cfg_shift (cfg_shift),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_sat   (out_sat),
      .out_ready (out_ready),
      .err       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fill_tile(input logic [AW-1:0] v);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            acc_in[r][c] = v;
   endtask

   task automatic fill_row(input int r, input logic [AW-1:0] v);
      for (int c = 0; c < SIZE; c++) acc_in[r][c] = v;
   endtask

   task automatic set_exp_all(input logic [DW-1:0] v);
      for (int r = 0; r < SIZE; r++) begin
         exp_lane[r] = v;
         exp_sat[r]  = 1'b0;
      end
   endtask

   // Offer the tile currently on acc_in for one cycle.
   task automatic send_tile(input logic last, input logic [SW-1:0] shift);
      acc_valid = 1'b1;
      acc_last  = last;
      cfg_shift = shift;
      check("acc_ready_before_accept", 128'(acc_ready), 128'(1));
      @(negedge clock);
      acc_valid = 1'b0;
      acc_last  = 1'b0;
   endtask

   // Drain rows 0..n_rows-1 against exp_lane/exp_sat. Optionally stall at
   // stall_row for 3 cycles, or offer an illegal tile at inject_row.
   task automatic drain(input int n_rows, input int stall_row, input int inject_row);
      logic [127:0] held;
      for (int r = 0; r < n_rows; r++) begin
         check("out_valid", 128'(out_valid), 128'(1));
         check("out_row", 128'(out_row), 128'(r));
         check("out_last", 128'(out_last), 128'(r == SIZE - 1));
         check("out_sat", 128'(out_sat), 128'(exp_sat[r]));
         check("out_data", 128'(out_data), {SIZE{exp_lane[r]}});
         if (r == stall_row) begin
            held      = 128'(out_data);
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clock);
               check("stall_row", 128'(out_row), 128'(r));
               check("stall_data", 128'(out_data), held);
               check("stall_valid", 128'(out_valid), 128'(1));
            end
            out_ready = 1'b1;
         end
         if (r == inject_row) begin
            fill_tile(48'h55);
            acc_valid = 1'b1;
            acc_last  = 1'b1;
            cfg_shift = 6'd0;
         end
         @(negedge clock);
         acc_valid = 1'b0;
         acc_last  = 1'b0;
      end
      if (n_rows == SIZE) begin
         check("acc_ready_after_drain", 128'(acc_ready), 128'(1));
         check("out_valid_after_drain", 128'(out_valid), 128'(0));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      acc_valid = 1'b0;
      acc_last  = 1'b0;
      cfg_shift = '0;
      out_ready = 1'b1;
      fill_tile('0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);

      // Reset state
      check("rst_acc_ready", 128'(acc_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_last", 128'(out_last), 128'(0));
      check("rst_out_sat", 128'(out_sat), 128'(0));
      check("rst_out_row", 128'(out_row), 128'(0));
      check("rst_err", 128'(err), 128'(0));

      // 1: single tile 0x100, shift 4 -> 0x0010
      fill_tile(48'h100);
      send_tile(1'b1, 6'd4);
      set_exp_all(16'h0010);
      drain(SIZE, -1, -1);

      // 2: three tiles 1,2,3 with shift 0 -> 6, then fresh single tile of 1
      fill_tile(48'd1); send_tile(1'b0, 6'd0);
      check("mid_group_no_valid", 128'(out_valid), 128'(0));
      fill_tile(48'd2); send_tile(1'b0, 6'd0);
      fill_tile(48'd3); send_tile(1'b1, 6'd0);
      set_exp_all(16'd6);
      drain(SIZE, -1, -1);
      fill_tile(48'd1); send_tile(1'b1, 6'd0);
      set_exp_all(16'd1);
      drain(SIZE, -1, -1);

      // 3a: rounding at shift 1: 5 -> 3, -5 -> -2, 4 -> 2, 0 -> 0
      fill_tile('0);
      fill_row(0, 48'd5);
      fill_row(1, -48'sd5);
      fill_row(2, 48'd4);
      send_tile(1'b1, 6'd1);
      set_exp_all(16'd0);
      exp_lane[0] = 16'd3;
      exp_lane[1] = 16'hFFFE;
      exp_lane[2] = 16'd2;
      drain(SIZE, -1, -1);

      // 3b: saturation at shift 0 on rows 0 and 1 only
      fill_tile(48'd7);
      fill_row(0, 48'h10000);
      fill_row(1, -48'sh10000);
      send_tile(1'b1, 6'd0);
      set_exp_all(16'd7);
      exp_lane[0] = 16'h7FFF; exp_sat[0] = 1'b1;
      exp_lane[1] = 16'h8000; exp_sat[1] = 1'b1;
      drain(SIZE, -1, -1);

      // 4: back-pressure at row 2; row r carries 3r+1
      for (int r = 0; r < SIZE; r++) fill_row(r, 48'(3 * r + 1));
      send_tile(1'b1, 6'd0);
      for (int r = 0; r < SIZE; r++) begin
         exp_lane[r] = 16'(3 * r + 1);
         exp_sat[r]  = 1'b0;
      end
      drain(SIZE, 2, -1);

      // 5: illegal tile during drain: err sticky, data intact (0x40>>2 rounded = 16)
      check("err_before_inject", 128'(err), 128'(0));
      fill_tile(48'h40);
      send_tile(1'b1, 6'd2);
      set_exp_all(16'd16);
      drain(SIZE, -1, 1);
      check("err_sticky", 128'(err), 128'(1));
      repeat (2) @(negedge clock);
      check("err_still_set", 128'(err), 128'(1));

      // 6: async reset during row 4
      fill_tile(48'd20);
      send_tile(1'b1, 6'd0);
      set_exp_all(16'd20);
      drain(4, -1, -1);
      check("row4_before_reset", 128'(out_row), 128'(4));
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 128'(out_valid), 128'(0));
      check("rst_async_out_last", 128'(out_last), 128'(0));
      check("rst_async_err", 128'(err), 128'(0));
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      check("post_rst_acc_ready", 128'(acc_ready), 128'(1));
      check("post_rst_out_valid", 128'(out_valid), 128'(0));
      fill_tile(48'd9);
      send_tile(1'b1, 6'd0);
      set_exp_all(16'd9);
      drain(SIZE, -1, -1);
      check("post_rst_err", 128'(err), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
